// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/D unified-memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int XLEN           = 32;
    localparam int ADDR_BITS      = 10;
    localparam int MEM_LAT_DEF    = 2;
    localparam int STARVE_MAX_DEF = 3;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of pipeline-side request/response signals and memory-side signals of the arbiter.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic                 flush_if;
    logic                 if_req;
    logic [ADDR_BITS-1:0] if_addr;
    logic                 if_gnt;
    logic                 if_rvalid;
    logic [XLEN-1:0]      if_rdata;
    logic                 d_req;
    logic                 d_we;
    logic                 d_byt;
    logic [ADDR_BITS-1:0] d_addr;
    logic [XLEN-1:0]      d_wdata;
    logic                 d_gnt;
    logic                 d_rvalid;
    logic [XLEN-1:0]      d_rdata;
    logic                 mem_en;
    logic                 mem_we;
    logic                 mem_byt;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [XLEN-1:0]      mem_wdata;
    logic [XLEN-1:0]      mem_rdata;
    logic                 busy;

    modport slave (
        input  flush_if, if_req, if_addr, d_req, d_we, d_byt, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_byt, mem_addr, mem_wdata, busy
    );

    modport master (
        output flush_if, if_req, if_addr, d_req, d_we, d_byt, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_byt, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// IF starvation counter and D-first priority select; grants only when the port can accept.
module mem_port_arbiter_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_can_grant,
    input  logic i_if_req,
    input  logic i_d_req,
    output logic o_grant_if,
    output logic o_grant_d
);

    localparam int            SW         = cnt_width(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] r_starve_cnt;
    logic          w_if_wins;

    // Priority select: D wins unless IF has been passed over STARVE_MAX times in a row.
    always_comb begin
        w_if_wins  = i_if_req && (r_starve_cnt == STARVE_LIM);
        o_grant_d  = i_can_grant && i_d_req && !w_if_wins;
        o_grant_if = i_can_grant && i_if_req && !o_grant_d;
    end

    // Counts consecutive D grants taken while IF is waiting, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= {SW{1'b0}};
        end else if (o_grant_if || !i_if_req) begin
            r_starve_cnt <= {SW{1'b0}};
        end else if (o_grant_d && (r_starve_cnt != STARVE_LIM)) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between fetch (IF) and data (D): one access in flight,
// responses routed to the owner, fetch responses dropped after a taken-branch flush.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam int            LW       = cnt_width(MEM_LAT - 1);
    localparam logic [LW-1:0] LAT_LOAD = LW'(MEM_LAT - 1);

    arb_state_e  r_state;
    owner_e      r_owner;
    logic [LW-1:0] r_lat_cnt;
    logic        r_kill;
    logic        r_store;

    logic w_resp;
    logic w_can_grant;
    logic w_grant_if;
    logic w_grant_d;
    logic w_grant;
    logic w_if_rvalid;
    logic w_d_rvalid;

    // The response cycle doubles as a grant slot; nothing is granted while reset is held.
    always_comb begin
        w_resp      = (r_state == ARB_WAIT) && (r_lat_cnt == {LW{1'b0}});
        w_can_grant = rst_n && ((r_state == ARB_IDLE) || w_resp);
        w_grant     = w_grant_if || w_grant_d;
    end

    mem_port_arbiter_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb_starve_ctr (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_can_grant (w_can_grant),
        .i_if_req    (bus.if_req),
        .i_d_req     (bus.d_req),
        .o_grant_if  (w_grant_if),
        .o_grant_d   (w_grant_d)
    );

    // Grant-cycle memory strobe and response routing to the current owner.
    always_comb begin
        bus.if_gnt  = w_grant_if;
        bus.d_gnt   = w_grant_d;
        bus.mem_en  = w_grant;
        bus.mem_we  = w_grant_d && bus.d_we;
        bus.mem_byt = w_grant_d && bus.d_byt;
        if (w_grant_d) begin
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_we ? bus.d_wdata : {XLEN{1'b0}};
        end else if (w_grant_if) begin
            bus.mem_addr  = bus.if_addr;
            bus.mem_wdata = {XLEN{1'b0}};
        end else begin
            bus.mem_addr  = {ADDR_BITS{1'b0}};
            bus.mem_wdata = {XLEN{1'b0}};
        end
        w_if_rvalid   = w_resp && (r_owner == OWNER_IF) && !r_kill;
        w_d_rvalid    = w_resp && (r_owner == OWNER_D);
        bus.if_rvalid = w_if_rvalid;
        bus.d_rvalid  = w_d_rvalid;
        bus.if_rdata  = w_if_rvalid ? bus.mem_rdata : {XLEN{1'b0}};
        bus.d_rdata   = (w_d_rvalid && !r_store) ? bus.mem_rdata : {XLEN{1'b0}};
        bus.busy      = (r_state == ARB_WAIT);
    end

    // Access FSM: a flush in the response cycle only kills a newly granted IF access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ARB_IDLE;
            r_owner   <= OWNER_IF;
            r_lat_cnt <= {LW{1'b0}};
            r_kill    <= 1'b0;
            r_store   <= 1'b0;
        end else if (w_grant) begin
            r_state   <= ARB_WAIT;
            r_lat_cnt <= LAT_LOAD;
            r_owner   <= w_grant_d ? OWNER_D : OWNER_IF;
            r_kill    <= w_grant_if && bus.flush_if;
            r_store   <= w_grant_d && bus.d_we;
        end else if (w_resp) begin
            r_state   <= ARB_IDLE;
            r_kill    <= 1'b0;
        end else if (r_state == ARB_WAIT) begin
            r_lat_cnt <= r_lat_cnt - LW'(1);
            r_kill    <= r_kill || ((r_owner == OWNER_IF) && bus.flush_if);
        end else begin
            r_state   <= r_state;
        end
    end

endmodule
